minmax_tracker: RTL and testbench
=================================

MINMAX_TRACKER -- requirements
Module: minmax_tracker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, sample width in bits (>=2).
REQ-002 The block SHALL have parameter FRAME_LEN, default 16, samples per frame (>=1).
REQ-003 The block SHALL have parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid  input  1  sample strobe, one sample accepted per cycle when high.
REQ-007 The block SHALL have port in_data  input  WIDTH  sample value.
REQ-008 The block SHALL have port clear  input  1  synchronous abort of the current frame.
REQ-009 The block SHALL have port run_min  output  WIDTH  running minimum of the current frame.
REQ-010 The block SHALL have port run_max  output  WIDTH  running maximum of the current frame.
REQ-011 The block SHALL have port frame_min  output  WIDTH  minimum of the last completed frame.
REQ-012 The block SHALL have port frame_max  output  WIDTH  maximum of the last completed frame.
REQ-013 The block SHALL have port frame_valid  output  1  one-cycle pulse per completed frame.
REQ-014 The block SHALL have port count  output  $clog2(FRAME_LEN+1)  samples accepted in the current frame.
REQ-015 The block SHALL have port busy  output  1  high while a frame is partially collected.
REQ-016 The block SHALL have port frame_cnt  output  8  completed-frame counter, modulo 256.

Function
REQ-017 The block SHALL implement states IDLE (no samples in frame) and TRACK (1..FRAME_LEN-1 samples); busy SHALL equal (state==TRACK).
REQ-018 In IDLE with in_valid=1, the block SHALL load run_min=run_max=in_data, set count=1, and enter TRACK; if FRAME_LEN==1 it SHALL instead complete the frame per REQ-020 and remain IDLE.
REQ-019 In TRACK with in_valid=1, the block SHALL update run_min=min(run_min,in_data), run_max=max(run_max,in_data), and count=count+1; equal values SHALL leave min/max unchanged.
REQ-020 On the edge accepting the FRAME_LEN-th sample, the block SHALL load frame_min/frame_max with the statistics including that sample, assert frame_valid for exactly the following cycle, increment frame_cnt (255 wraps to 0), reset count to 0, reset run_min/run_max to the idle values of REQ-024, and enter IDLE.
REQ-021 A sample presented in the cycle immediately after frame completion SHALL be accepted as the first sample of the next frame, with zero gap cycles required.
REQ-022 Cycles with in_valid=0 SHALL change no state; gaps mid-frame SHALL NOT affect results.
REQ-023 When clear=1, the block SHALL enter IDLE, set count=0, and restore the run_min/run_max idle values; clear SHALL win over a simultaneous in_valid (sample dropped) and over a simultaneous frame completion (no frame_valid, frame outputs and frame_cnt unchanged).
REQ-024 Idle values SHALL be run_min = largest representable value (SIGNED=0: all ones; SIGNED=1: 0 followed by ones) and run_max = smallest representable value (SIGNED=0: all zeros; SIGNED=1: 1 followed by zeros).
REQ-025 Comparisons SHALL be unsigned when SIGNED=0 and signed when SIGNED=1; no arithmetic widening SHALL occur.
REQ-026 All outputs SHALL be registered; run_min, run_max, and count SHALL reflect an accepted sample on the same edge that accepts it.

Reset
REQ-027 When rst=0, the block SHALL immediately enter IDLE with count=0, busy=0, frame_valid=0, frame_cnt=0, frame_min=frame_max=0, and run_min/run_max at the idle values.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first sample after release SHALL start a new frame.

Verification (WIDTH=8, FRAME_LEN=4, SIGNED=0 unless stated)
REQ-029 The bench SHALL verify: reset -> run_min=0xFF, run_max=0x00, count=0, busy=0, frame_valid=0, frame_cnt=0.
REQ-030 The bench SHALL verify: samples 5,3,9,3 on consecutive cycles -> frame_valid high one cycle after the 4th sample, frame_min=3, frame_max=9, frame_cnt=1, busy=0.
REQ-031 The bench SHALL verify: samples 7,2, then clear together with sample 1 -> count=0, run_min=0xFF, and frame_min/frame_max/frame_cnt unchanged, with no frame_valid.
REQ-032 The bench SHALL verify: 8 back-to-back samples 1,2,3,4,200,100,50,150 -> two frame_valid pulses, first (1,4), second (50,200).
REQ-033 The bench SHALL verify: SIGNED=1 with samples 0x80,0x7F,0xFF,0x01 -> frame_min=0x80, frame_max=0x7F; idle run_min=0x7F, run_max=0x80.
REQ-034 The bench SHALL verify: 256 frames with random in_valid gaps -> frame_cnt returns to 0, and every frame matches the reference model.

Source files
------------

// File: rtl/minmax_tracker.sv
// rtl/minmax_tracker.sv - per-frame running and completed min/max tracker
module minmax_tracker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int SIGNED    = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               clear,
    output logic [WIDTH-1:0]                   run_min,
    output logic [WIDTH-1:0]                   run_max,
    output logic [WIDTH-1:0]                   frame_min,
    output logic [WIDTH-1:0]                   frame_max,
    output logic                               frame_valid,
    output logic [$clog2(FRAME_LEN+1)-1:0]     count,
    output logic                               busy,
    output logic [7:0]                         frame_cnt
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    // Idle values are the identities of min/max so the first sample always wins.
    localparam logic [WIDTH-1:0] MIN_IDLE = (SIGNED != 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MAX_IDLE = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

    typedef enum logic {IDLE, TRACK} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_run_min;
    logic [WIDTH-1:0]   r_run_max;
    logic [WIDTH-1:0]   r_frame_min;
    logic [WIDTH-1:0]   r_frame_max;
    logic               r_frame_valid;
    logic [CW-1:0]      r_count;
    logic [7:0]         r_frame_cnt;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_min;
    logic [WIDTH-1:0]   w_max;

    function automatic logic f_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0)
            return $signed(a) < $signed(b);
        else
            return a < b;
    endfunction

    assign w_accept = in_valid && !clear;
    assign w_last   = w_accept && (r_count == CW'(FRAME_LEN - 1));
    assign w_min    = (r_state == IDLE || f_less(in_data, r_run_min)) ? in_data : r_run_min;
    assign w_max    = (r_state == IDLE || f_less(r_run_max, in_data)) ? in_data : r_run_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (clear)
            w_next_state = IDLE;
        else if (w_accept)
            w_next_state = w_last ? IDLE : TRACK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_min     <= MIN_IDLE;
            r_run_max     <= MAX_IDLE;
            r_frame_min   <= '0;
            r_frame_max   <= '0;
            r_frame_valid <= 1'b0;
            r_count       <= '0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            if (clear) begin
                r_count   <= '0;
                r_run_min <= MIN_IDLE;
                r_run_max <= MAX_IDLE;
            end else if (w_accept) begin
                if (w_last) begin
                    r_frame_min   <= w_min;
                    r_frame_max   <= w_max;
                    r_frame_valid <= 1'b1;
                    r_frame_cnt   <= r_frame_cnt + 8'd1;
                    r_count       <= '0;
                    r_run_min     <= MIN_IDLE;
                    r_run_max     <= MAX_IDLE;
                end else begin
                    r_run_min <= w_min;
                    r_run_max <= w_max;
                    r_count   <= r_count + CW'(1);
                end
            end
        end
    end

    always_comb begin
        run_min     = r_run_min;
        run_max     = r_run_max;
        frame_min   = r_frame_min;
        frame_max   = r_frame_max;
        frame_valid = r_frame_valid;
        count       = r_count;
        busy        = (r_state == TRACK);
        frame_cnt   = r_frame_cnt;
    end

endmodule

// File: tb/tb_minmax_tracker.sv
// tb/tb_minmax_tracker.sv - scoreboard bench for minmax_tracker
module tb_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       clear = 1'b0;
    logic [7:0] run_min, run_max, frame_min, frame_max, frame_cnt;
    logic       frame_valid, busy;
    logic [2:0] count;

    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_clear = 1'b0;
    logic [7:0] s_run_min, s_run_max, s_frame_min, s_frame_max, s_frame_cnt;
    logic       s_frame_valid, s_busy;
    logic [2:0] s_count;

    always #5 clk = ~clk;

    minmax_tracker #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .run_min(run_min), .run_max(run_max), .frame_min(frame_min), .frame_max(frame_max),
        .frame_valid(frame_valid), .count(count), .busy(busy), .frame_cnt(frame_cnt)
    );

    minmax_tracker #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .clear(s_clear),
        .run_min(s_run_min), .run_max(s_run_max), .frame_min(s_frame_min), .frame_max(s_frame_max),
        .frame_valid(s_frame_valid), .count(s_count), .busy(s_busy), .frame_cnt(s_frame_cnt)
    );

    typedef struct {
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] fc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_total = 0;
    int         n_bad = 0;
    int         frames_done = 0;
    logic [7:0] m_min = 8'hFF;
    logic [7:0] m_max = 8'h00;
    logic [7:0] m_fcnt = 8'h00;
    int         m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        logic exp_fv;
        exp_fv   = 1'b0;
        in_valid = v;
        in_data  = d;
        clear    = c;
        if (c) begin
            m_cnt = 0; m_min = 8'hFF; m_max = 8'h00;
        end else if (v) begin
            if (d < m_min) m_min = d;
            if (d > m_max) m_max = d;
            m_cnt++;
            if (m_cnt == 4) begin
                m_fcnt = m_fcnt + 8'd1;
                sb_q.push_back('{m_min, m_max, m_fcnt});
                m_cnt = 0; m_min = 8'hFF; m_max = 8'h00;
                exp_fv = 1'b1;
                frames_done++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        chk("run_min", run_min, m_min);
        chk("run_max", run_max, m_max);
        chk("count", count, m_cnt);
        chk("busy", busy, m_cnt != 0);
        chk("frame_valid", frame_valid, exp_fv);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_run_min", run_min, 8'hFF);
        chk("rst_run_max", run_max, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_frame_min", frame_min, 0);
        chk("rst_frame_max", frame_max, 0);
        m_cnt = 0; m_min = 8'hFF; m_max = 8'h00; m_fcnt = 8'h00;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && frame_valid) begin
            if (sb_q.size() == 0) begin
                chk("fv_spurious", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_frame_min", frame_min, mon_e.mn);
                chk("sb_frame_max", frame_max, mon_e.mx);
                chk("sb_frame_cnt", frame_cnt, mon_e.fc);
            end
        end
    end

    initial begin
        do_reset();
        chk("s_idle_min", s_run_min, 8'h7F);
        chk("s_idle_max", s_run_max, 8'h80);

        // Signed instance: 0x80,0x7F,0xFF,0x01
        begin
            logic [7:0] s_vec [4];
            s_vec = '{8'h80, 8'h7F, 8'hFF, 8'h01};
            for (int i = 0; i < 4; i++) begin
                s_valid = 1'b1;
                s_data  = s_vec[i];
                @(posedge clk);
                #1;
            end
            s_valid = 1'b0;
            chk("s_fv", s_frame_valid, 1);
            chk("s_frame_min", s_frame_min, 8'h80);
            chk("s_frame_max", s_frame_max, 8'h7F);
            chk("s_run_min_after", s_run_min, 8'h7F);
            chk("s_run_max_after", s_run_max, 8'h80);
            chk("s_busy", s_busy, 0);
        end

        step(1, 8'd5, 0); step(1, 8'd3, 0); step(1, 8'd9, 0); step(1, 8'd3, 0);
        chk("f1_min", frame_min, 8'd3);
        chk("f1_max", frame_max, 8'd9);
        chk("f1_cnt", frame_cnt, 8'd1);
        step(0, 8'd0, 0);

        step(1, 8'd7, 0); step(1, 8'd2, 0); step(1, 8'd1, 1);
        chk("clr_frame_min", frame_min, 8'd3);
        chk("clr_frame_max", frame_max, 8'd9);
        chk("clr_frame_cnt", frame_cnt, 8'd1);

        // Clear coinciding with what would be the completing sample
        step(1, 8'd10, 0); step(1, 8'd20, 0); step(1, 8'd30, 0); step(1, 8'd40, 1);
        chk("clr_last_cnt", frame_cnt, 8'd1);

        begin
            logic [7:0] vec8 [8];
            vec8 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd200, 8'd100, 8'd50, 8'd150};
            for (int i = 0; i < 8; i++) step(1, vec8[i], 0);
        end
        chk("b2b_cnt", frame_cnt, 8'd3);
        chk("b2b_min", frame_min, 8'd50);
        chk("b2b_max", frame_max, 8'd200);

        step(1, 8'd77, 0); step(1, 8'd66, 0);
        do_reset();
        step(1, 8'd9, 0); step(1, 8'd8, 0); step(1, 8'd250, 0); step(1, 8'd0, 0);
        chk("post_rst_cnt", frame_cnt, 8'd1);

        do_reset();
        frames_done = 0;
        while (frames_done < 256) begin
            if ($urandom_range(0, 3) == 0)
                step(0, 8'($urandom_range(0, 255)), 0);
            else
                step(1, 8'($urandom_range(0, 255)), 0);
        end
        chk("wrap_frame_cnt", frame_cnt, 8'd0);
        step(0, 8'd0, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
